// File: rtl/memory_responder.sv
// Memory-side responder for the MAR/MDR port: single-word read/write requests served
// from an internal word-addressed RAM after WAIT_CYCLES wait states, with a Done pulse.
module memory_responder #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Address,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] MdataOut,
    output logic              Done,
    output logic              Busy,
    output logic              Error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);
    localparam int unsigned DEPTH   = 1 << ADDR_W;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rd;
    logic              r_wr;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_req;
    logic              w_req_err;
    logic              w_accept;
    logic              w_exec;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_rd;
    logic              w_wr;
    logic              w_err;

    assign w_req     = Read | Write;
    assign w_req_err = (|Address[31:ADDR_W]) | (Read & Write);
    assign w_accept  = (r_state == S_IDLE) & w_req;

    // With zero wait states the access happens on the acceptance edge itself,
    // so it must use the live request rather than the not-yet-latched copy.
    always_comb begin
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_rd    = r_rd;
        w_wr    = r_wr;
        w_err   = r_err;
        w_exec  = (r_state == S_WAIT) && (r_cnt == 4'd1);
        if (WAIT_CYCLES == 0) begin
            w_addr  = Address[ADDR_W-1:0];
            w_wdata = WriteData;
            w_rd    = Read;
            w_wr    = Write;
            w_err   = w_req_err;
            w_exec  = w_accept;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_err    <= 1'b0;
            MdataOut <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= LP_WAIT;
                r_addr  <= Address[ADDR_W-1:0];
                r_wdata <= WriteData;
                r_rd    <= Read;
                r_wr    <= Write;
                r_err   <= w_req_err;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_exec && w_rd && !w_err) begin
                MdataOut <= r_mem[w_addr];
            end
        end
    end

    // RAM is deliberately not reset; reset only aborts the access by forcing IDLE.
    always_ff @(posedge clk) begin
        if (w_exec && w_wr && !w_err) begin
            r_mem[w_addr] <= w_wdata;
        end
    end

    assign Done  = (r_state == S_DONE);
    assign Busy  = (r_state != S_IDLE);
    assign Error = Done & r_err;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: vector table, reset/back-to-back sequences,
// zero-wait-state instance and randomized traffic against an array-based model.
module tb_memory_responder;

    logic        clk;
    logic        reset;
    logic [31:0] addr, wdata, mdata;
    logic        rd, wr, done, busy, err;
    logic [31:0] addr0, wdata0, mdata0;
    logic        rd0, wr0, done0, busy0, err0;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [512];
    bit          ref_valid [512];
    logic [31:0] ref_mdata;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        bit          err;
        logic [31:0] md;
    } vec_t;

    vec_t tbl[12];

    memory_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .Address(addr), .WriteData(wdata),
        .Read(rd), .Write(wr), .MdataOut(mdata), .Done(done), .Busy(busy), .Error(err)
    );

    memory_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .Address(addr0), .WriteData(wdata0),
        .Read(rd0), .Write(wr0), .MdataOut(mdata0), .Done(done0), .Busy(busy0), .Error(err0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: applies the request's effect and returns whether it should be rejected.
    function automatic bit model_apply(input bit r, input bit w, input logic [31:0] a,
                                       input logic [31:0] d);
        bit e;
        e = (a > 32'h1FF) || (r && w);
        if (!e) begin
            if (w) begin
                ref_mem[a[8:0]]   = d;
                ref_valid[a[8:0]] = 1'b1;
            end
            if (r) ref_mdata = ref_mem[a[8:0]];
        end
        return e;
    endfunction

    // Default instance: Done expected in the 3rd cycle after the request cycle.
    task automatic req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input string tag, output logic act_err, output logic [31:0] act_md,
                       output bit exp_err);
        int n;
        exp_err = model_apply(r, w, a, d);
        rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0; addr = $urandom; wdata = $urandom;
        chk({tag, " busy"}, busy, 1'b1);
        n = 0;
        while (!done && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, 2);
        act_err = err;
        act_md  = mdata;
        @(posedge clk); #1;
        chk({tag, " done pulse"}, {30'd0, done, err}, 32'd0);
    endtask

    task automatic req0(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input string tag, input bit exp_e, input logic [31:0] exp_md);
        int n;
        rd0 = r; wr0 = w; addr0 = a; wdata0 = d;
        @(posedge clk); #1;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = $urandom; wdata0 = $urandom;
        n = 0;
        while (!done0 && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, 0);
        chk({tag, " error"}, err0, exp_e);
        chk({tag, " mdata"}, mdata0, exp_md);
        @(posedge clk); #1;
        chk({tag, " done pulse"}, {30'd0, done0, busy0}, 32'd0);
    endtask

    initial begin
        logic [31:0] amd;
        logic        aerr;
        bit          eerr;
        int          last, pulses, lowcnt;
        bit          seen;

        tbl[0]  = '{1'b0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h9999_9999, 1'b1, 32'hDEAD_BEEF};
        tbl[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h1111_1111};
        tbl[6]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'h1111_1111};
        tbl[7]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h1111_1111};
        tbl[8]  = '{1'b0, 1'b1, 32'h0000_01FF, 32'h0BAD_F00D, 1'b0, 32'h1111_1111};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_01FF, 32'h0000_0000, 1'b0, 32'h0BAD_F00D};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_0205, 32'h5555_5555, 1'b1, 32'h0BAD_F00D};
        tbl[11] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};

        for (int i = 0; i < 512; i++) ref_valid[i] = 1'b0;
        ref_mdata = 32'h0;

        reset = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        #3;
        chk("reset mdata", mdata, 32'h0);
        chk("reset flags", {29'd0, done, busy, err}, 32'd0);
        chk("reset0 mdata", mdata0, 32'h0);
        chk("reset0 flags", {29'd0, done0, busy0, err0}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            req(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, $sformatf("vec%0d", i), aerr, amd, eerr);
            chk($sformatf("vec%0d error", i), aerr, tbl[i].err);
            chk($sformatf("vec%0d mdata", i), amd, tbl[i].md);
        end

        // Reset during WAIT aborts the write to 0x20.
        wr = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        wr = 1'b0;
        chk("abort busy before", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort mdata", mdata, 32'h0);
        chk("abort done", done, 1'b0);
        #1 reset = 1'b1;
        ref_mdata = 32'h0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("abort no done", seen, 1'b0);
        req(1'b1, 1'b0, 32'h20, 32'h0, "abort read", aerr, amd, eerr);
        chk("abort read mdata", amd, 32'hCAFE_F00D);
        chk("abort read error", aerr, 1'b0);

        // Read held high: one access every WAIT_CYCLES+2 cycles.
        rd = 1'b1; addr = 32'h5;
        last = 0; pulses = 0; lowcnt = 0;
        for (int c = 0; c < 40 && pulses < 4; c++) begin
            @(posedge clk); #1;
            if (!busy) lowcnt++;
            if (done) begin
                chk("hold mdata", mdata, 32'hDEAD_BEEF);
                if (pulses > 0) begin
                    chk("hold period", c - last, 4);
                    chk("hold busy low", lowcnt, 1);
                end
                last = c;
                pulses++;
                lowcnt = 0;
            end
        end
        rd = 1'b0;
        chk("hold pulses", pulses, 4);
        ref_mdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("hold released", busy, 1'b0);

        // Zero wait states.
        req0(1'b0, 1'b1, 32'h1, 32'hA5A5_A5A5, "w0 write", 1'b0, 32'h0);
        req0(1'b1, 1'b0, 32'h1, 32'h0, "w0 read", 1'b0, 32'hA5A5_A5A5);
        req0(1'b1, 1'b0, 32'h400, 32'h0, "w0 oor", 1'b1, 32'hA5A5_A5A5);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            bit          r, w;
            int          k;
            k = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 63));
            r = 1'b0; w = 1'b0;
            if (k == 0) begin
                a = 32'h200 | $urandom;
                r = 1'b1;
            end else if (k == 1) begin
                r = 1'b1; w = 1'b1;
            end else if (k < 5 || !ref_valid[a[8:0]]) begin
                w = 1'b1;
            end else begin
                r = 1'b1;
            end
            req(r, w, a, $urandom, $sformatf("rnd%0d", i), aerr, amd, eerr);
            chk($sformatf("rnd%0d error", i), aerr, eerr);
            chk($sformatf("rnd%0d mdata", i), amd, ref_mdata);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
